// File: rtl/render_pkg.sv
// Shared types for the rectangle renderer: op record layout and FSM states.
// Latency: n/a (types only).
// Backpressure: n/a.
// Contents: rect_op_t (queued fill-rectangle op) and state_t (IDLE/CLEAR/LOAD/DRAW).
package render_pkg;

   // Op fields are sized for the default 640x480 screen. Smaller instances
   // use the same record, so every geometry check is made on full field widths.
   localparam int DEF_HOR = 640;
   localparam int DEF_VER = 480;
   localparam int OP_XW   = $clog2(DEF_HOR);
   localparam int OP_YW   = $clog2(DEF_VER);
   localparam int OP_CW   = 8;   // widest supported PIXEL_WIDTH

   typedef struct packed {
      logic [OP_XW-1:0] x;
      logic [OP_YW-1:0] y;
      logic [OP_XW:0]   w;
      logic [OP_YW:0]   h;
      logic [OP_CW-1:0] color;
   } rect_op_t;

   typedef enum logic [1:0] {IDLE, CLEAR, LOAD, DRAW} state_t;

endpackage

// File: rtl/sync_fifo.sv
// Pointer-based synchronous FIFO with occupancy count; show-ahead read data.
// Latency: a pushed entry is visible on o_dat the cycle after the push.
// Backpressure: pushes while full and pops while empty are ignored.
// Ports: i_push/i_dat write side, i_pop/o_dat read side, o_full/o_empty status.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_dat,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_dat,
   output logic             o_full,
   output logic             o_empty
);
   localparam int PTRW = $clog2(DEPTH);
   localparam int CNTW = PTRW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTRW-1:0]  r_wptr;
   logic [PTRW-1:0]  r_rptr;
   logic [CNTW-1:0]  r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_count == CNTW'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign w_do_push = i_push & ~o_full;
   assign w_do_pop  = i_pop & ~o_empty;
   assign o_dat     = r_mem[r_rptr];

   // Storage carries no reset; only the pointers define validity.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wptr] <= i_dat;
   end

   // DEPTH is a power of two, so the pointers wrap on their own.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + 1'b1;
         if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/rect_renderer.sv
// Rasterises queued fill-rectangle ops into the back framebuffer, clearing it on every swap.
// Latency: first pixel write 3 ce cycles after an op is accepted by an idle, empty block.
// Backpressure: op_ready drops while the op queue is full; ops are accepted in every state.
// Ports: clk/rst(async, active-low)/ce; swap pulse; op/op_valid/op_ready; wr_en/wr_addr/wr_data; idle.
module rect_renderer
   import render_pkg::*;
#(
   parameter int                     HOR_ACTIVE_PIXELS = 640,
   parameter int                     VER_ACTIVE_PIXELS = 480,
   parameter int                     PIXEL_WIDTH       = 1,
   parameter int                     FIFO_DEPTH        = 4,
   parameter logic [PIXEL_WIDTH-1:0] CLEAR_COLOR       = '0
) (
   input  logic                                                   clk,
   input  logic                                                   rst,
   input  logic                                                   ce,
   input  logic                                                   swap,
   input  rect_op_t                                               op,
   input  logic                                                   op_valid,
   output logic                                                   op_ready,
   output logic                                                   wr_en,
   output logic [$clog2(HOR_ACTIVE_PIXELS*VER_ACTIVE_PIXELS)-1:0] wr_addr,
   output logic [PIXEL_WIDTH-1:0]                                 wr_data,
   output logic                                                   idle
);
   localparam int NPIX = HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS;
   localparam int AW   = $clog2(NPIX);
   localparam int XEW  = OP_XW + 2;   // room for x+w without overflow
   localparam int YEW  = OP_YW + 2;

   state_t               r_state;
   logic                 r_swap_pend;
   logic [AW-1:0]        r_cnt;
   logic [OP_XW-1:0]     r_x0;
   logic [OP_XW-1:0]     r_cx;
   logic [OP_YW-1:0]     r_cy;
   logic [XEW-1:0]       r_x_end;
   logic [YEW-1:0]       r_y_end;
   logic [PIXEL_WIDTH-1:0] r_color;
   logic                 r_wr_en;
   logic [AW-1:0]        r_wr_addr;
   logic [PIXEL_WIDTH-1:0] r_wr_data;

   logic                 w_push;
   logic                 w_pop;
   logic                 w_full;
   logic                 w_empty;
   rect_op_t             w_head;
   logic [XEW-1:0]       w_xsum;
   logic [YEW-1:0]       w_ysum;
   logic [XEW-1:0]       w_x_end;
   logic [YEW-1:0]       w_y_end;
   logic                 w_drop;
   logic                 w_cx_last;
   logic                 w_cy_last;
   logic [AW-1:0]        w_draw_addr;
   logic                 w_unused_color;

   assign op_ready = ~w_full;
   assign w_push   = ce & op_valid & ~w_full;
   assign w_pop    = ce & (r_state == LOAD);

   sync_fifo #(
      .WIDTH ($bits(rect_op_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_op_fifo (
      .clk     (clk),
      .rst_n   (rst),
      .i_push  (w_push),
      .i_dat   (op),
      .i_pop   (w_pop),
      .o_dat   (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Clip the head op against the screen edge at widened precision.
   assign w_xsum  = XEW'(w_head.x) + XEW'(w_head.w);
   assign w_ysum  = YEW'(w_head.y) + YEW'(w_head.h);
   assign w_x_end = (w_xsum > XEW'(HOR_ACTIVE_PIXELS)) ? XEW'(HOR_ACTIVE_PIXELS) : w_xsum;
   assign w_y_end = (w_ysum > YEW'(VER_ACTIVE_PIXELS)) ? YEW'(VER_ACTIVE_PIXELS) : w_ysum;
   assign w_drop  = (w_head.w == '0) || (w_head.h == '0) ||
                    (XEW'(w_head.x) >= XEW'(HOR_ACTIVE_PIXELS)) ||
                    (YEW'(w_head.y) >= YEW'(VER_ACTIVE_PIXELS));

   // Colour bits above PIXEL_WIDTH are ignored by narrow instances.
   assign w_unused_color = ^w_head.color;

   assign w_cx_last   = ((XEW'(r_cx) + XEW'(1)) == r_x_end);
   assign w_cy_last   = ((YEW'(r_cy) + YEW'(1)) == r_y_end);
   assign w_draw_addr = AW'((32'(r_cy) * HOR_ACTIVE_PIXELS) + 32'(r_cx));

   // Registered strobe is masked while ce is low; since everything holds,
   // the same write is re-presented on the next enabled cycle.
   assign wr_en   = r_wr_en & ce;
   assign wr_addr = r_wr_addr;
   assign wr_data = r_wr_data;
   assign idle    = (r_state == IDLE) & w_empty & ~r_swap_pend;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_swap_pend <= 1'b0;
         r_cnt       <= '0;
         r_x0        <= '0;
         r_cx        <= '0;
         r_cy        <= '0;
         r_x_end     <= '0;
         r_y_end     <= '0;
         r_color     <= '0;
         r_wr_en     <= 1'b0;
         r_wr_addr   <= '0;
         r_wr_data   <= '0;
      end else if (ce) begin
         r_wr_en <= 1'b0;
         case (r_state)
            IDLE: begin
               // A pending clear wins over queued ops.
               if (r_swap_pend) begin
                  r_state     <= CLEAR;
                  r_swap_pend <= 1'b0;
                  r_cnt       <= '0;
               end else if (!w_empty) begin
                  r_state <= LOAD;
               end
            end
            CLEAR: begin
               r_wr_en   <= 1'b1;
               r_wr_addr <= r_cnt;
               r_wr_data <= CLEAR_COLOR;
               if (swap) begin
                  r_cnt <= '0;                 // new swap: start the clear over
               end else if (r_cnt == AW'(NPIX - 1)) begin
                  r_state <= IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            LOAD: begin
               if (w_drop) begin
                  r_state <= IDLE;
               end else begin
                  r_x0    <= w_head.x;
                  r_cx    <= w_head.x;
                  r_cy    <= w_head.y;
                  r_x_end <= w_x_end;
                  r_y_end <= w_y_end;
                  r_color <= PIXEL_WIDTH'(w_head.color);
                  r_state <= DRAW;
               end
            end
            DRAW: begin
               r_wr_en   <= 1'b1;
               r_wr_addr <= w_draw_addr;
               r_wr_data <= r_color;
               if (w_cx_last) begin
                  r_cx <= r_x0;
                  if (w_cy_last) r_state <= IDLE;
                  else           r_cy    <= r_cy + 1'b1;
               end else begin
                  r_cx <= r_cx + 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
         // Swaps outside CLEAR are remembered; inside CLEAR they restart it.
         if (swap && (r_state != CLEAR)) r_swap_pend <= 1'b1;
      end
   end

endmodule
